// File: rtl/chroma_frame_sequencer_if.sv
// Stream channel between the reader, the chroma converter and the writer.
//   t_valid/t_ready : handshake, a beat transfers when both are high at a clock edge
//   t_data          : DATA_WIDTH bits, 4 pixels as Y0 U Y1 V
//   t_keep          : byte enables
//   t_last          : marks the final beat of a picture
// The master modport drives payload and valid; the slave modport drives ready.
interface nasti_stream_channel #(
  parameter int unsigned DATA_WIDTH = 64
);
  logic                    t_valid;
  logic                    t_ready;
  logic [DATA_WIDTH-1:0]   t_data;
  logic [DATA_WIDTH/8-1:0] t_keep;
  logic                    t_last;

  modport master (output t_valid, output t_data, output t_keep, output t_last, input t_ready);
  modport slave  (input t_valid, input t_data, input t_keep, input t_last, output t_ready);
endinterface

// File: rtl/chroma_frame_sequencer.sv
// Frame-level controller that steers one 4:2:2 picture through the chroma converter.
// On start it latches the picture size, gates exactly width*height/4 beats from the reader
// into the converter (generating t_last on the final beat), passes converter output straight
// through to the writer and pulses done once the converter's last output beat is accepted.
//   clk, rst              : clock, synchronous active-low reset
//   start, abort          : one-cycle commands (start honoured in idle, abort in feed/drain)
//   cfg_width, cfg_height : picture size in pixels / lines
//   busy, done, err       : status; err is sticky until the next accepted start
//   line_cnt, out_cnt     : current input line, output beats accepted in this frame
//   up, cvt_src           : reader -> converter input passthrough
//   cvt_dst, down         : converter output -> writer passthrough
module chroma_frame_sequencer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DIM_W      = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DIM_W-1:0]     cfg_width,
  input  logic [DIM_W-1:0]     cfg_height,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [DIM_W-1:0]     line_cnt,
  output logic [2*DIM_W-1:0]   out_cnt,
  nasti_stream_channel.slave   up,
  nasti_stream_channel.master  cvt_src,
  nasti_stream_channel.slave   cvt_dst,
  nasti_stream_channel.master  down
);

  typedef enum logic [2:0] {StIdle, StLoad, StFeed, StDrain, StDone} state_e;

  state_e             state_q;
  logic [DIM_W-1:0]   width_q, height_q, bpl_q, beat_cnt_q, line_cnt_q;
  logic [2*DIM_W-1:0] out_cnt_q;
  logic               err_q, busy_q, done_q;
  // Converter signalled its last output before our last input: finish at the final input beat.
  logic               early_q;

  logic in_feed, out_open, last_beat, beat_wrap, in_hs, out_hs, out_last_hs, cfg_bad;

  always_comb begin
    in_feed     = (state_q == StFeed);
    out_open    = in_feed || (state_q == StDrain);
    beat_wrap   = (beat_cnt_q == bpl_q - DIM_W'(1));
    last_beat   = beat_wrap && (line_cnt_q == height_q - DIM_W'(1));
    cfg_bad     = (width_q[1:0] != 2'b00) || (width_q == '0) || (height_q == '0);

    up.t_ready      = in_feed && cvt_src.t_ready;
    cvt_src.t_valid = in_feed && up.t_valid;
    cvt_src.t_data  = up.t_data[DATA_WIDTH-1:0];
    cvt_src.t_keep  = up.t_keep[DATA_WIDTH/8-1:0];
    cvt_src.t_last  = in_feed && last_beat;

    cvt_dst.t_ready = out_open && down.t_ready;
    down.t_valid    = out_open && cvt_dst.t_valid;
    down.t_data     = cvt_dst.t_data[DATA_WIDTH-1:0];
    down.t_keep     = cvt_dst.t_keep[DATA_WIDTH/8-1:0];
    down.t_last     = cvt_dst.t_last;

    in_hs       = in_feed && up.t_valid && cvt_src.t_ready;
    out_hs      = out_open && cvt_dst.t_valid && down.t_ready;
    out_last_hs = out_hs && cvt_dst.t_last;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      width_q    <= '0;
      height_q   <= '0;
      bpl_q      <= '0;
      beat_cnt_q <= '0;
      line_cnt_q <= '0;
      out_cnt_q  <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      early_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (out_hs) out_cnt_q <= out_cnt_q + 1'b1;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            width_q  <= cfg_width;
            height_q <= cfg_height;
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= StLoad;
          end
        end
        StLoad: begin
          bpl_q      <= width_q >> 2;
          beat_cnt_q <= '0;
          line_cnt_q <= '0;
          out_cnt_q  <= '0;
          early_q    <= 1'b0;
          if (cfg_bad) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            state_q <= StFeed;
          end
        end
        StFeed: begin
          if (in_hs) begin
            if (up.t_last && !last_beat) err_q <= 1'b1;
            if (beat_wrap) begin
              beat_cnt_q <= '0;
              line_cnt_q <= line_cnt_q + 1'b1;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
          if (out_last_hs) begin
            err_q   <= 1'b1;
            early_q <= 1'b1;
          end
          // Abort takes priority over the final input beat.
          if (abort) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if (in_hs && last_beat) begin
            if (early_q || out_last_hs) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (abort) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if (out_last_hs) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign line_cnt = line_cnt_q;
  assign out_cnt  = out_cnt_q;

endmodule

// File: doc/chroma_frame_sequencer.md
# chroma_frame_sequencer

Frame-level controller that sequences one 4:2:2 picture through the `yuv422to444` converter. It sits between the upstream stream reader and the converter input, and between the converter output and the downstream writer. On a start command it gates exactly `cfg_width*cfg_height/4` 64-bit beats into the converter, generating `t_last` on the final input beat. It passes converter output through to the writer and reports completion once the converter's final output beat has been accepted.

## Interface
Parameters:
- `DATA_WIDTH`, 64: stream data width in bits. Each beat carries 4 pixels as Y0 U Y1 V pairs.
- `DIM_W`, 12: bit width of the picture dimension fields and line counter.

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous and active-low: sampled on the rising edge of `clk`, asserted when 0.
- `start`  in  1  one-cycle start pulse; honoured only in IDLE.
- `abort`  in  1  synchronous abort; honoured in FEED and DRAIN.
- `cfg_width`  in  DIM_W  pixels per line; must be a nonzero multiple of 4.
- `cfg_height`  in  DIM_W  lines per frame; must be nonzero.
- `busy`  out  1  high in LOAD, FEED and DRAIN.
- `done`  out  1  one-cycle pulse when the frame finishes, aborts or is rejected.
- `err`  out  1  sticky error flag; cleared by an accepted `start`.
- `line_cnt`  out  DIM_W  index of the current input line.
- `out_cnt`  out  2*DIM_W  count of output beats accepted downstream in this frame.
- `up`  `nasti_stream_channel` slave, DATA_WIDTH: from the reader.
- `cvt_src`  `nasti_stream_channel` master: to the converter input.
- `cvt_dst`  `nasti_stream_channel` slave: from the converter output.
- `down`  `nasti_stream_channel` master: to the writer.

## Operation
- States: IDLE, LOAD, FEED, DRAIN, DONE.
- IDLE:
  - `up.t_ready=0`, `cvt_src.t_valid=0`, `cvt_dst.t_ready=0`, `down.t_valid=0`.
  - On `start`, latch `cfg_width` and `cfg_height`, clear `err`, and go to LOAD.
- LOAD (1 cycle):
  - `bpl = cfg_width>>2`. Clear `beat_cnt`, `line_cnt` and `out_cnt`.
  - If `cfg_width[1:0]!=0`, `cfg_width==0` or `cfg_height==0`: set `err` and go to DONE, with no traffic.
  - Otherwise go to FEED.
- FEED, input path (combinational passthrough):
  - `cvt_src.t_valid=up.t_valid`, `up.t_ready=cvt_src.t_ready`.
  - `t_data` and `t_keep` pass through unchanged.
  - `cvt_src.t_last = (beat_cnt==bpl-1) && (line_cnt==height-1)`. Upstream `up.t_last` is not forwarded.
  - On each `up` handshake, `beat_cnt` increments. When it wraps at `bpl-1` it returns to 0 and `line_cnt` increments.
  - A handshake carrying `cvt_src.t_last` moves the state to DRAIN.
- FEED and DRAIN, output path (combinational passthrough):
  - `down.t_valid=cvt_dst.t_valid`, `cvt_dst.t_ready=down.t_ready`.
  - `t_data`, `t_keep` and `t_last` pass through.
  - `out_cnt` increments on each `down` handshake.
- DRAIN:
  - `up.t_ready=0`, `cvt_src.t_valid=0`.
  - A `down` handshake with `t_last=1` moves the state to DONE.
- DONE: `done=1` for one cycle, then IDLE.
- Error conditions (`err` set; sequencing continues):
  - `up.t_last=1` on a handshake that is not the final beat.
  - A `cvt_dst` t_last handshake while still in FEED. The frame then completes at the final input beat and the state goes directly to DONE.
- Abort: `abort` in FEED or DRAIN sets `err` and moves to DONE on the next edge. Both passthroughs close in DONE. Any data still inside the converter is the caller's responsibility to flush via `rst`.
- `start` while busy: ignored; latched config is unchanged.

## Timing
- Reset (`rst==0` at an edge):
  - State goes to IDLE.
  - `busy`, `done`, `err`, `line_cnt` and `out_cnt` are 0.
  - All `t_valid` and `t_ready` outputs are 0 (they are combinational from IDLE).
  - Reset mid-frame discards the frame with no `done` pulse.
- Start latency: `start` sampled at edge N puts the block in LOAD in cycle N+1. FEED begins in cycle N+2, the earliest cycle `up.t_ready` can be 1.
- Passthrough latency is 0 cycles in both directions. There is no buffering, so backpressure propagates combinationally.
- Counters and state update on the clock edge at which the handshake (`t_valid && t_ready`) is sampled.
- `done` asserts in the cycle after the final `down` t_last handshake (or after LOAD rejection or abort) and lasts exactly 1 cycle.
- Simultaneous events:
  - Final input handshake together with an output t_last handshake in FEED: go to DONE.
  - `abort` together with the final handshake: abort wins, `err=1`.
- Maximum frame: (2^DIM_W-4)×(2^DIM_W-1). `out_cnt` does not overflow at 2*DIM_W bits.

## Test plan
- Nominal frame, width 8 × height 2, all ready high, 4 input beats 1..4 -> `cvt_src.t_last` high on beat 4 only; `line_cnt` reads 0,0,1,1; `done` pulses one cycle after the downstream t_last handshake; `err=0`.
- Backpressure, width 16 × height 4, `down.t_ready` toggling every cycle and `up.t_valid` gaps -> data order is preserved with no drops or duplicates; exactly 16 input handshakes; `out_cnt` equals the converter's emitted beat count.
- Bad config, `cfg_width=6` -> `err=1`; `done` at start+2; `up.t_ready` never high; `busy` high for exactly 1 cycle.
- Abort on the 3rd beat of an 8×2 frame -> next cycle is DONE with `done=1` and `err=1`; `up.t_ready=0` thereafter; a second `start` clears `err` and runs a clean frame.
- Early `up.t_last` on beat 2 of a 4-beat frame -> `err=1`; the frame still completes with `cvt_src.t_last` on beat 4.
- `start` pulsed during FEED is ignored. `rst=0` mid-FEED leaves all outputs at 0 the next cycle with no `done` pulse, and a fresh frame runs correctly afterwards.
